// File: rtl/sqrt_arb_pkg.sv
// Shared encodings and widths for the squareRoot arbiter slice.
// The optional watchdog is enabled with SQRT_ARB_TIMEOUT_EN.
package sqrt_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'b001;
  localparam logic [2:0] ST_BUSY    = 3'b010;
  localparam logic [2:0] ST_RELEASE = 3'b100;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    BUSY    = ST_BUSY,
    RELEASE = ST_RELEASE
  } arb_state_e;

  localparam int OPW              = 8;
  localparam int RESW             = 4;
  localparam int SQRT_TIMEOUT_CYC = 24;
  localparam int WDOG_W           = 5;

endpackage

// File: rtl/sqrt_arbiter_pick.sv
// Combinational round-robin picker: the search starts just after the last
// granted index and wraps, so the most recently served requester ranks last.
module sqrt_rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  lastGrant_i,
  output logic            any_o,
  output logic [IDW-1:0]  winner_o
);

  logic [IDW-1:0] cand;

  // Walk from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(lastGrant_i) + k) % NREQ);
      if (req_i[cand]) begin
        any_o    = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one squareRoot unit between NREQ requesters with round-robin grant,
// st/done sequencing and a one-cycle ack. Optional watchdog: SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] n_flat,
  output logic [NREQ-1:0]   ack,
  output logic [3:0]        res,
  output logic              err,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              sq_st,
  output logic [7:0]        sq_n,
  input  logic              sq_done,
  input  logic [3:0]        sq_sqrt
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  lastGrant_q, lastGrant_d;
  logic [OPW-1:0]  sqN_q, sqN_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [RESW-1:0] res_q, res_d;
  logic            anyReq;
  logic [IDW-1:0]  winnerIdx;
  logic [OPW-1:0]  opSel;
`ifdef SQRT_ARB_TIMEOUT_EN
  logic              err_q, err_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  sqrt_rr_pick #(.NREQ(NREQ), .IDW(IDW)) uPick (
    .req_i       (req),
    .lastGrant_i (lastGrant_q),
    .any_o       (anyReq),
    .winner_o    (winnerIdx)
  );

  always_comb begin
    opSel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winnerIdx == IDW'(i)) opSel = n_flat[OPW*i +: OPW];
    end
  end

  // Operands are captured only at grant; later n_flat/req changes are ignored.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    sqN_d       = sqN_q;
    ack_d       = '0;
    res_d       = res_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    err_d       = 1'b0;
    wdog_d      = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d = winnerIdx;
          sqN_d   = opSel;
          state_d = BUSY;
`ifdef SQRT_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      BUSY: begin
`ifdef SQRT_ARB_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
`endif
        if (sq_done) begin
          res_d          = sq_sqrt;
          ack_d[owner_q] = 1'b1;
          lastGrant_d    = owner_q;
          state_d        = RELEASE;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        // An aborted owner also drops to lowest priority so a dead unit cannot starve others.
        else if (wdog_q == WDOG_W'(SQRT_TIMEOUT_CYC - 1)) begin
          res_d          = '0;
          err_d          = 1'b1;
          ack_d[owner_q] = 1'b1;
          lastGrant_d    = owner_q;
          state_d        = RELEASE;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastGrant_q <= IDW'(NREQ - 1);
      sqN_q       <= '0;
      ack_q       <= '0;
      res_q       <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      sqN_q       <= sqN_d;
      ack_q       <= ack_d;
      res_q       <= res_d;
`ifdef SQRT_ARB_TIMEOUT_EN
      err_q       <= err_d;
      wdog_q      <= wdog_d;
`endif
    end
  end

  // st comes straight from one state flop, so it cannot glitch.
  assign sq_st = (state_q == BUSY);
  assign busy  = (state_q == BUSY) || (state_q == RELEASE);
  assign sq_n  = sqN_q;
  assign ack   = ack_q;
  assign res   = res_q;
  assign owner = owner_q;
`ifdef SQRT_ARB_TIMEOUT_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule
